// File: rtl/m_store_buffer_pkg.sv
// Shared definitions for the M-stage store buffer: byte-enable opcodes,
// default depth, lane count and the word-address slice helper.
`ifndef M_STORE_BUFFER_PKG_SV
`define M_STORE_BUFFER_PKG_SV

// Word-address slice of a byte address; AW must be visible at the use site.
`define SB_WADDR(a) a[AW-1:2]

package m_store_buffer_pkg;

    // Store width opcodes produced by the byte-enable stage.
    typedef enum logic [1:0] {
        BE_NONE = 2'd0,
        BE_B    = 2'd1,
        BE_H    = 2'd2,
        BE_W    = 2'd3
    } be_op_e;

    localparam int SB_DEPTH = 4;
    localparam int SB_BEW   = 4;

    // Lane enables for a store of the given width at byte offset off.
    function automatic logic [SB_BEW-1:0] be_mask(input be_op_e op, input logic [1:0] off);
        logic [SB_BEW-1:0] m;
        case (op)
            BE_B:    m = 4'b0001 << off;
            BE_H:    m = off[1] ? 4'b1100 : 4'b0011;
            BE_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

`endif

// File: rtl/m_sb_lane_merge.sv
// Per-lane merge of a new partial store into an existing buffered word.
module m_sb_lane_merge
    import m_store_buffer_pkg::*;
(
    input  logic [SB_BEW-1:0]   old_be_i,
    input  logic [8*SB_BEW-1:0] old_data_i,
    input  logic [SB_BEW-1:0]   new_be_i,
    input  logic [8*SB_BEW-1:0] new_data_i,
    output logic [SB_BEW-1:0]   merged_be_o,
    output logic [8*SB_BEW-1:0] merged_data_o
);

    // New lanes overwrite old bytes; untouched lanes keep their byte and enable.
    always_comb begin
        merged_be_o   = old_be_i | new_be_i;
        merged_data_o = old_data_i;
        for (int i = 0; i < SB_BEW; i++) begin
            if (new_be_i[i]) begin
                merged_data_o[8*i +: 8] = new_data_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/m_store_buffer.sv
// Memory-stage store buffer: queues word-granular stores, coalesces into the
// youngest non-head entry, drains to the data-memory bus, and raises stall on
// a full buffer or on a load hitting a pending store word.
//
// Handshake: a store transfers on i_st_valid & o_st_ready; a memory write
// transfers on o_mem_valid & i_mem_ready. A valid side holds its payload
// stable until the transfer, and ready never depends on the same-cycle
// transfer of the other port (decisions use registered occupancy only).
module m_store_buffer
    import m_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_st_valid,
    input  logic [AW-1:0]          i_st_addr,
    input  logic [SB_BEW-1:0]      i_st_byteen,
    input  logic [31:0]            i_st_wdata,
    output logic                   o_st_ready,
    input  logic                   i_ld_valid,
    input  logic [AW-1:0]          i_ld_addr,
    output logic                   o_ld_conflict,
    output logic                   o_stall,
    output logic                   o_mem_valid,
    output logic [AW-1:0]          o_mem_addr,
    output logic [SB_BEW-1:0]      o_mem_byteen,
    output logic [31:0]            o_mem_wdata,
    input  logic                   i_mem_ready,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-3:0]       waddr_q  [DEPTH];
    logic [SB_BEW-1:0]   byteen_q [DEPTH];
    logic [31:0]         wdata_q  [DEPTH];
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d, young;
    logic [CW-1:0]       count_q, count_d;

    logic [AW-3:0]       st_wa, ld_wa;
    logic                st_zero, has_room, coal_hit, do_alloc, do_pop, ld_hit;
    logic [SB_BEW-1:0]   mrg_be;
    logic [31:0]         mrg_data;
    logic                unused_addr_lsbs;

    assign st_wa            = `SB_WADDR(i_st_addr);
    assign ld_wa            = `SB_WADDR(i_ld_addr);
    assign unused_addr_lsbs = ^{i_st_addr[1:0], i_ld_addr[1:0]};
    assign young            = tail_q - 1'b1;

    m_sb_lane_merge u_merge (
        .old_be_i      (byteen_q[young]),
        .old_data_i    (wdata_q[young]),
        .new_be_i      (i_st_byteen),
        .new_data_i    (i_st_wdata),
        .merged_be_o   (mrg_be),
        .merged_data_o (mrg_data)
    );

    // Accept/coalesce/pop decisions and next pointer/count values.
    always_comb begin
        st_zero  = ~|i_st_byteen;
        has_room = count_q < CW'(DEPTH);
        // Needing count>=2 keeps the head (possibly mid-handshake) out of reach.
        coal_hit = i_st_valid & (count_q >= CW'(2)) & (waddr_q[young] == st_wa);
        do_alloc = i_st_valid & ~st_zero & ~coal_hit & has_room;
        do_pop   = (count_q != '0) & i_mem_ready;
        head_d   = do_pop   ? head_q + 1'b1 : head_q;
        tail_d   = do_alloc ? tail_q + 1'b1 : tail_q;
        count_d  = count_q;
        if (do_alloc && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_alloc && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Load conflict scan over every occupied slot, head included.
    always_comb begin
        ld_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) && (waddr_q[head_q + PW'(k)] == ld_wa)) begin
                ld_hit = 1'b1;
            end
        end
    end

    // Entry storage, pointers and occupancy; reset discards all contents.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i]  <= '0;
                byteen_q[i] <= '0;
                wdata_q[i]  <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_alloc) begin
                waddr_q[tail_q]  <= st_wa;
                byteen_q[tail_q] <= i_st_byteen;
                wdata_q[tail_q]  <= i_st_wdata;
            end else if (coal_hit) begin
                byteen_q[young] <= mrg_be;
                wdata_q[young]  <= mrg_data;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign o_st_ready    = has_room | coal_hit | st_zero;
    assign o_ld_conflict = i_ld_valid & ld_hit;
    assign o_stall       = (i_st_valid & ~o_st_ready) | o_ld_conflict;
    assign o_mem_valid   = (count_q != '0);
    assign o_mem_addr    = {waddr_q[head_q], 2'b00};
    assign o_mem_byteen  = byteen_q[head_q];
    assign o_mem_wdata   = wdata_q[head_q];
    assign o_count       = count_q;

endmodule
